// File: rtl/object_transition.sv
// ============================================================================
//  Module   : object_transition
//  Purpose  : X/Y position integrator, one saturating step per moveclk rise.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module object_transition (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       moveclk,
   input  logic [9:0] initPosX,
   input  logic [8:0] initPosY,
   input  logic [9:0] vx,
   input  logic [8:0] vy,
   input  logic [1:0] dx,
   input  logic [1:0] dy,
   output logic [9:0] posx,
   output logic [8:0] posy
);

   localparam logic signed [11:0] c_XMAX = 12'sd639;
   localparam logic signed [11:0] c_YMAX = 12'sd479;

   logic [9:0] r_posx;
   logic [8:0] r_posy;
   logic       r_mc;

   logic              w_step;
   logic signed [11:0] w_sumx;
   logic signed [11:0] w_sumy;
   logic signed [11:0] w_clx;
   logic signed [11:0] w_cly;
   logic [9:0]        w_nx;
   logic [8:0]        w_ny;
   logic [9:0]        w_initx;
   logic [8:0]        w_inity;

   // Saturate a signed 12-bit intermediate into [0, lim].
   function automatic logic signed [11:0] f_clamp(input logic signed [11:0] v,
                                                  input logic signed [11:0] lim);
      if (v < 12'sd0)
         f_clamp = 12'sd0;
      else if (v > lim)
         f_clamp = lim;
      else
         f_clamp = v;
   endfunction

   assign w_step  = moveclk & ~r_mc;
   assign w_initx = (initPosX > 10'd639) ? 10'd639 : initPosX;
   assign w_inity = (initPosY > 9'd479)  ? 9'd479  : initPosY;

   always_comb begin
      w_sumx = $signed({2'b00, r_posx});
      w_sumy = $signed({3'b000, r_posy});
      if (dx[1]) begin
         if (dx[0])
            w_sumx = $signed({2'b00, r_posx}) - $signed({2'b00, vx});
         else
            w_sumx = $signed({2'b00, r_posx}) + $signed({2'b00, vx});
      end
      if (dy[1]) begin
         if (dy[0])
            w_sumy = $signed({3'b000, r_posy}) - $signed({3'b000, vy});
         else
            w_sumy = $signed({3'b000, r_posy}) + $signed({3'b000, vy});
      end
      w_clx = f_clamp(w_sumx, c_XMAX);
      w_cly = f_clamp(w_sumy, c_YMAX);
      w_nx  = w_clx[9:0];
      w_ny  = w_cly[8:0];
   end

   // Edge history tracks moveclk unconditionally so disabled ticks are dropped.
   always_ff @(posedge clk) begin
      r_mc <= moveclk;
      if (rst) begin
         r_posx <= w_initx;
         r_posy <= w_inity;
      end else if (w_step && en) begin
         r_posx <= w_nx;
         r_posy <= w_ny;
      end
   end

   assign posx = r_posx;
   assign posy = r_posy;

endmodule

`default_nettype wire

// File: tb/tb_object_transition.sv
// ============================================================================
//  Module   : tb_object_transition
//  Purpose  : Scoreboard bench for object_transition with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_object_transition;

   logic       clk;
   logic       rst;
   logic       en;
   logic       moveclk;
   logic [9:0] initPosX;
   logic [8:0] initPosY;
   logic [9:0] vx;
   logic [8:0] vy;
   logic [1:0] dx;
   logic [1:0] dy;
   logic [9:0] posx;
   logic [8:0] posy;

   typedef struct {
      string      name;
      logic [9:0] x;
      logic [8:0] y;
   } exp_t;

   exp_t q_exp[$];
   int   n_checks;
   int   n_fail;

   object_transition u_dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .moveclk  (moveclk),
      .initPosX (initPosX),
      .initPosY (initPosY),
      .vx       (vx),
      .vy       (vy),
      .dx       (dx),
      .dy       (dy),
      .posx     (posx),
      .posy     (posy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: the position registers are the DUT's output; compare on negedge.
   always @(negedge clk) begin
      while (q_exp.size() > 0) begin
         exp_t e;
         e = q_exp.pop_front();
         n_checks++;
         if (posx !== e.x || posy !== e.y) begin
            n_fail++;
            $display("FAIL %s: got (%0d,%0d) expected (%0d,%0d)",
                     e.name, posx, posy, e.x, e.y);
         end
      end
   end

   task automatic push(input string name, input int x, input int y);
      exp_t e;
      e.name = name;
      e.x    = 10'(x);
      e.y    = 9'(y);
      q_exp.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int ix, input int iy);
      moveclk  = 1'b0;
      initPosX = 10'(ix);
      initPosY = 9'(iy);
      rst      = 1'b1;
      cyc();
      rst      = 1'b0;
      cyc();
   endtask

   task automatic tick();
      moveclk = 1'b1;
      cyc();
      moveclk = 1'b0;
      cyc();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      en       = 1'b0;
      moveclk  = 1'b0;
      initPosX = '0;
      initPosY = '0;
      vx = '0; vy = '0; dx = 2'b00; dy = 2'b00;
      cyc();

      do_reset(320, 240);
      push("reset_load", 320, 240);
      do_reset(700, 500);
      push("reset_clamp", 639, 479);

      do_reset(320, 240);
      en = 1'b1; vx = 10'd5; dx = 2'b10; vy = 9'd3; dy = 2'b10;
      moveclk = 1'b1;
      cyc();
      push("pos_step", 325, 243);
      for (int i = 0; i < 10; i++) begin
         cyc();
         push("hold_high", 325, 243);
      end
      moveclk = 1'b0;
      cyc();

      do_reset(4, 2);
      vx = 10'd10; dx = 2'b11; vy = 9'd10; dy = 2'b11;
      tick();
      push("floor_1", 0, 0);
      tick();
      push("floor_2", 0, 0);

      do_reset(635, 475);
      vx = 10'd1023; dx = 2'b10; vy = 9'd511; dy = 2'b10;
      tick();
      push("ceiling", 639, 479);

      do_reset(10, 400);
      vx = 10'd3; dx = 2'b11; vy = 9'd100; dy = 2'b10;
      tick();
      push("mixed_dir", 7, 479);

      do_reset(100, 100);
      vx = 10'd50; dx = 2'b01; dy = 2'b00;
      tick();
      push("no_move_bit", 100, 100);
      en = 1'b0; vx = 10'd7; dx = 2'b10;
      for (int i = 0; i < 3; i++) begin
         tick();
         push("en_low", 100, 100);
      end
      en = 1'b1;
      tick();
      push("en_resume", 107, 100);

      vx = 10'd0; dx = 2'b10; vy = 9'd0; dy = 2'b11;
      tick();
      push("zero_vel", 107, 100);

      dx = 2'b10; vx = 10'd9; dy = 2'b00;
      initPosX = 10'd200; initPosY = 9'd50;
      moveclk = 1'b1;
      rst = 1'b1;
      cyc();
      push("rst_priority", 200, 50);
      rst = 1'b0;
      cyc();
      push("no_spurious_1", 200, 50);
      cyc();
      push("no_spurious_2", 200, 50);
      moveclk = 1'b0;
      cyc();
      moveclk = 1'b1;
      cyc();
      push("post_rst_step", 209, 50);
      moveclk = 1'b0;

      repeat (3) cyc();
      if (q_exp.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", q_exp.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
